// File: rtl/encode_frame_decoder.sv
// Sync-word decoder for the serial_rx word stream: scan-control flags, encoder
// position frames (sync + ENC_WORDS payload words), payload timeout and counters.
module encode_frame_decoder #(
  parameter int DATA_WIDTH  = 16,
  parameter int ENC_WORDS   = 2,
  parameter int TIMEOUT_CYC = 1024,
  parameter int CNT_WIDTH   = 16,
  parameter logic [DATA_WIDTH-1:0] SYNC_ENCODE     = 'hECDE,
  parameter logic [DATA_WIDTH-1:0] SYNC_SCAN_BEGIN = 'h5A51,
  parameter logic [DATA_WIDTH-1:0] SYNC_SCAN_TEST  = 'h5A53,
  parameter logic [DATA_WIDTH-1:0] SYNC_SCAN_END   = 'h5A50
) (
  input  logic                            clk_i,
  input  logic                            rst_n_i,
  input  logic                            rx_valid_i,
  input  logic [DATA_WIDTH-1:0]           rx_data_i,
  input  logic                            clr_cnt_i,
  output logic                            encode_zero_flag_o,
  output logic                            enc_valid_o,
  output logic [ENC_WORDS*DATA_WIDTH-1:0] enc_data_o,
  output logic                            scan_start_flag_o,
  output logic                            scan_test_flag_o,
  output logic                            frame_err_o,
  output logic [CNT_WIDTH-1:0]            frame_cnt_o,
  output logic [CNT_WIDTH-1:0]            err_cnt_o
);

  localparam int EW = ENC_WORDS * DATA_WIDTH;
  localparam int SW = (ENC_WORDS > 1) ? (ENC_WORDS - 1) * DATA_WIDTH : DATA_WIDTH;
  localparam int TW = $clog2(TIMEOUT_CYC) + 1;
  localparam int IW = 3;

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_PAYLOAD = 1'b1;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [0:0]           state_q, state_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [TW-1:0]        tmo_q, tmo_d;
  logic [SW-1:0]        shadow_q, shadow_d;
  logic [EW-1:0]        shift_w;
  logic [EW-1:0]        enc_data_q, enc_data_d;
  logic                 ezf_q, ezf_d, encv_q, encv_d, ferr_q, ferr_d;
  logic                 start_q, start_d, test_q, test_d;
  logic [CNT_WIDTH-1:0] fcnt_q, fcnt_d, ecnt_q, ecnt_d;
  logic                 frame_inc, err_inc;

  // Shadow keeps only the earlier words; the current word completes the value.
  generate
    if (ENC_WORDS > 1) begin : g_multi
      assign shift_w = {shadow_q, rx_data_i};
    end else begin : g_single
      assign shift_w = rx_data_i;
    end
  endgenerate

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    tmo_d      = tmo_q;
    shadow_d   = shadow_q;
    enc_data_d = enc_data_q;
    start_d    = start_q;
    test_d     = test_q;
    ezf_d      = 1'b0;
    encv_d     = 1'b0;
    ferr_d     = 1'b0;
    frame_inc  = 1'b0;
    err_inc    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rx_valid_i) begin
          if (rx_data_i == SYNC_ENCODE) begin
            ezf_d   = 1'b1;
            idx_d   = '0;
            tmo_d   = '0;
            state_d = ST_PAYLOAD;
          end else if (rx_data_i == SYNC_SCAN_BEGIN) begin
            start_d = 1'b1;
            test_d  = 1'b0;
          end else if (rx_data_i == SYNC_SCAN_TEST) begin
            start_d = 1'b1;
            test_d  = 1'b1;
          end else if (rx_data_i == SYNC_SCAN_END) begin
            start_d = 1'b0;
          end else begin
            ferr_d  = 1'b1;
            err_inc = 1'b1;
          end
        end
      end
      ST_PAYLOAD: begin
        // A word on the timeout cycle wins over the timeout.
        if (rx_valid_i) begin
          tmo_d    = '0;
          shadow_d = shift_w[SW-1:0];
          if (idx_q == IW'(ENC_WORDS - 1)) begin
            enc_data_d = shift_w;
            encv_d     = 1'b1;
            frame_inc  = 1'b1;
            state_d    = ST_IDLE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
          ferr_d  = 1'b1;
          err_inc = 1'b1;
          state_d = ST_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    fcnt_d = clr_cnt_i ? '0 : (frame_inc ? sat_inc(fcnt_q) : fcnt_q);
    ecnt_d = clr_cnt_i ? '0 : (err_inc ? sat_inc(ecnt_q) : ecnt_q);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      tmo_q      <= '0;
      enc_data_q <= '0;
      ezf_q      <= 1'b0;
      encv_q     <= 1'b0;
      ferr_q     <= 1'b0;
      start_q    <= 1'b0;
      test_q     <= 1'b0;
      fcnt_q     <= '0;
      ecnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      tmo_q      <= tmo_d;
      enc_data_q <= enc_data_d;
      ezf_q      <= ezf_d;
      encv_q     <= encv_d;
      ferr_q     <= ferr_d;
      start_q    <= start_d;
      test_q     <= test_d;
      fcnt_q     <= fcnt_d;
      ecnt_q     <= ecnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    shadow_q <= shadow_d;
  end

  assign encode_zero_flag_o = ezf_q;
  assign enc_valid_o        = encv_q;
  assign enc_data_o         = enc_data_q;
  assign scan_start_flag_o  = start_q;
  assign scan_test_flag_o   = test_q;
  assign frame_err_o        = ferr_q;
  assign frame_cnt_o        = fcnt_q;
  assign err_cnt_o          = ecnt_q;

endmodule

// File: doc/encode_frame_decoder.md
Name: encode_frame_decoder

Overview:
Parametrised successor to the serial sync-word decoder. Takes the word stream from serial_rx and decodes encoder-zero and scan-control sync words. An encoder sync word is followed by ENC_WORDS payload words, which the block assembles into an encoder position value. Adds a payload timeout, error/frame counters and a counter-clear input; sits between serial_rx and the scan/acquisition control logic.

Parameters:
DATA_WIDTH, 16, width of one received word
ENC_WORDS, 2, payload words after SYNC_ENCODE (legal 1..4), MS word first
TIMEOUT_CYC, 1024, max clk_i cycles allowed between payload words (>=2)
CNT_WIDTH, 16, width of frame and error counters
SYNC_ENCODE, 'hECDE, encoder sync word
SYNC_SCAN_BEGIN, 'h5A51, scan start (normal mode)
SYNC_SCAN_TEST, 'h5A53, scan start (test mode)
SYNC_SCAN_END, 'h5A50, scan stop

Ports:
clk_i  in  1  sole clock
rst_n_i  in  1  synchronous reset, active-low
rx_valid_i  in  1  one-cycle strobe, word on rx_data_i valid
rx_data_i  in  DATA_WIDTH  received word
clr_cnt_i  in  1  synchronous clear of frame_cnt_o and err_cnt_o
encode_zero_flag_o  out  1  one-cycle pulse, SYNC_ENCODE accepted
enc_valid_o  out  1  one-cycle pulse, enc_data_o updated
enc_data_o  out  ENC_WORDS*DATA_WIDTH  assembled encoder value
scan_start_flag_o  out  1  level, scan active
scan_test_flag_o  out  1  level, test mode
frame_err_o  out  1  one-cycle pulse, payload timeout or unknown word
frame_cnt_o  out  CNT_WIDTH  completed encoder frames, saturating
err_cnt_o  out  CNT_WIDTH  errors, saturating

Behaviour:
- Single clock, synchronous active-low reset. Reset value of every output is 0.
- FSM states: IDLE and PAYLOAD. Reset, including mid-PAYLOAD, forces IDLE, discards the partial payload, and counts no error.
- IDLE, rx_valid_i=1, word decoded as follows:
  - SYNC_ENCODE: encode_zero_flag_o pulses on the next cycle (latency 1). Word index is cleared, timeout counter is cleared, go to PAYLOAD.
  - SYNC_SCAN_BEGIN: start=1, test=0 on the next cycle.
  - SYNC_SCAN_TEST: start=1, test=1.
  - SYNC_SCAN_END: start=0; test holds its value.
  - Any other word: frame_err_o pulses and err_cnt_o increments.
- PAYLOAD:
  - Every valid word is raw payload, including words equal to sync words. Scan flags are not touched.
  - Words shift into the shadow register MS word first.
  - On the ENC_WORDS-th word: enc_data_o is loaded and enc_valid_o pulses on the next cycle. frame_cnt_o increments. Go to IDLE.
  - enc_data_o holds its value until the next complete frame. A partial frame never changes it.
- Timeout: the counter increments each PAYLOAD cycle with rx_valid_i=0 and clears on each valid word.
  - When it reaches TIMEOUT_CYC-1: frame_err_o pulses, err_cnt_o increments, go to IDLE.
  - A valid word arriving on that same cycle is accepted, and the timeout does not fire.
- Counters saturate at all-ones.
  - clr_cnt_i wins over a simultaneous increment; the counter reads 0 on the next cycle.
- Back-to-back rx_valid_i on consecutive cycles must be accepted with no lost words.
- An encode frame completing and a sync word arriving on the following cycle are both handled.
- All flags and pulses are registered; there are no combinational paths from inputs to outputs.

Test Plan:
- Reset then ENCODE frame: rx words ECDE, 1234, 5678 (ENC_WORDS=2) -> encode_zero_flag_o pulses 1 cycle after ECDE; enc_valid_o pulses 1 cycle after 5678; enc_data_o=32'h12345678; frame_cnt_o=1.
- Scan sequence 5A53, 5A50, 5A51, 5A50 -> (start,test) = (1,1), (0,1), (1,0), (0,0).
- Payload containing sync values: ECDE, 5A51, ECDE -> enc_data_o=32'h5A51ECDE; scan_start_flag_o stays 0; only one encode_zero pulse.
- Timeout: ECDE, 0xAAAA, then idle for TIMEOUT_CYC cycles -> frame_err_o pulses once; err_cnt_o=1; enc_data_o unchanged; next ECDE, 1111, 2222 gives 32'h11112222.
- Unknown word 0x0000 in IDLE, with clr_cnt_i asserted on the same cycle as a second error -> first error gives err_cnt_o=1; after the clear cycle err_cnt_o=0.
- rst_n_i=0 asserted after ECDE, 0x1234 -> all outputs 0 next cycle; subsequent 5A51 is decoded as a scan start, not as payload.
